// File: rtl/shared_counter_arb_pkg.sv
// Shared types and constants for the shared_counter_arb block.
package shared_counter_arb_pkg;
  localparam int DEF_NREQ  = 4;
  localparam int DEF_WIDTH = 32;

  localparam logic [1:0] OP_INC  = 2'b00;
  localparam logic [1:0] OP_DEC  = 2'b01;
  localparam logic [1:0] OP_LOAD = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;

  typedef enum logic {
    ST_ARB = 1'b0,
    ST_ACK = 1'b1
  } state_t;
endpackage

// File: rtl/shared_counter_arb_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above the pointer, mod NREQ.
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [2:0]      i_ptr,
  output logic [NREQ-1:0] o_win,
  output logic [2:0]      o_idx
);
  logic w_found;
  int   w_c;

  always_comb begin
    o_win   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_c     = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_c = (int'(i_ptr) + k) % NREQ;
      if (!w_found && i_req[w_c]) begin
        w_found    = 1'b1;
        o_win[w_c] = 1'b1;
        o_idx      = 3'(w_c);
      end
    end
  end
endmodule

// File: rtl/shared_counter_arb.sv
// Round-robin sequencer sharing one counter among NREQ requesters (ARB -> ACK per command).
// Define SHARED_CNT_SAT_EN to saturate INC/DEC instead of wrapping; wrap then flags a blocked step.
module shared_counter_arb
  import shared_counter_arb_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [2*NREQ-1:0]     op,
  input  logic [WIDTH*NREQ-1:0] ld_val,
  output logic [NREQ-1:0]       gnt,
  output logic [2:0]            gnt_id,
  output logic                  busy,
  output logic [WIDTH-1:0]      count,
  output logic                  wrap
);
  state_t           r_state;
  logic [2:0]       r_ptr;
  logic [NREQ-1:0]  r_gnt;
  logic [2:0]       r_gnt_id;
  logic             r_busy;
  logic             r_wrap;
  logic [WIDTH-1:0] r_count;

  logic [NREQ-1:0]  w_win;
  logic [2:0]       w_idx;
  logic [1:0]       w_op;
  logic [WIDTH-1:0] w_ld;
  logic [WIDTH-1:0] w_nxt;
  logic             w_wrap;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .i_req (req),
    .i_ptr (r_ptr),
    .o_win (w_win),
    .o_idx (w_idx)
  );

  // Mux the winner's command out of the flattened per-requester buses
  always_comb begin
    w_op = OP_INC;
    w_ld = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_win[i]) begin
        w_op = op[2*i +: 2];
        w_ld = ld_val[WIDTH*i +: WIDTH];
      end
    end
  end

  always_comb begin
    w_nxt  = r_count;
    w_wrap = 1'b0;
    case (w_op)
      OP_INC: begin
        if (&r_count) begin
          w_wrap = 1'b1;
`ifdef SHARED_CNT_SAT_EN
          w_nxt  = r_count;
`else
          w_nxt  = '0;
`endif
        end else begin
          w_nxt = r_count + WIDTH'(1);
        end
      end
      OP_DEC: begin
        if (r_count == '0) begin
          w_wrap = 1'b1;
`ifdef SHARED_CNT_SAT_EN
          w_nxt  = r_count;
`else
          w_nxt  = '1;
`endif
        end else begin
          w_nxt = r_count - WIDTH'(1);
        end
      end
      OP_LOAD: w_nxt = w_ld;
      default: w_nxt = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= ST_ARB;
      r_ptr    <= '0;
      r_gnt    <= '0;
      r_gnt_id <= '0;
      r_busy   <= 1'b0;
      r_wrap   <= 1'b0;
      r_count  <= '0;
    end else begin
      case (r_state)
        ST_ARB: begin
          if (|req) begin
            r_gnt    <= w_win;
            r_gnt_id <= w_idx;
            r_count  <= w_nxt;
            r_wrap   <= w_wrap;
            r_busy   <= 1'b1;
            r_ptr    <= (w_idx == 3'(NREQ-1)) ? 3'd0 : w_idx + 3'd1;
            r_state  <= ST_ACK;
          end
        end
        ST_ACK: begin
          r_gnt   <= '0;
          r_busy  <= 1'b0;
          r_wrap  <= 1'b0;
          r_state <= ST_ARB;
        end
        default: r_state <= ST_ARB;
      endcase
    end
  end

  assign gnt    = r_gnt;
  assign gnt_id = r_gnt_id;
  assign busy   = r_busy;
  assign count  = r_count;
  assign wrap   = r_wrap;
endmodule

// File: tb/tb_shared_counter_arb.sv
// Directed self-checking bench for shared_counter_arb (NREQ=4, WIDTH=32).
module tb_shared_counter_arb;
  localparam int NREQ  = 4;
  localparam int WIDTH = 32;
  localparam logic [1:0] INC = 2'b00, DEC = 2'b01, LD = 2'b10, CLR = 2'b11;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [2*NREQ-1:0]     op;
  logic [WIDTH*NREQ-1:0] ld_val;
  logic [NREQ-1:0]       gnt;
  logic [2:0]            gnt_id;
  logic                  busy;
  logic [WIDTH-1:0]      count;
  logic                  wrap;

  int n_cmp = 0;
  int n_err = 0;

  shared_counter_arb #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .req(req), .op(op), .ld_val(ld_val),
    .gnt(gnt), .gnt_id(gnt_id), .busy(busy), .count(count), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raise one requester's command and tick until its grant appears (bounded)
  task automatic do_cmd(input int r, input logic [1:0] o, input logic [WIDTH-1:0] v);
    int n;
    req = '0;
    req[r] = 1'b1;
    op[2*r +: 2] = o;
    ld_val[WIDTH*r +: WIDTH] = v;
    n = 0;
    do begin
      tick();
      n++;
    end while (gnt == '0 && n < 8);
    chk("grant_latency", 64'(n), 64'd1);
  endtask

  task automatic release_req();
    req = '0;
    tick();
    chk("ack_end_gnt", 64'(gnt), 64'd0);
    chk("ack_end_busy", 64'(busy), 64'd0);
  endtask

  logic [WIDTH-1:0] exp_inc_wrap, exp_dec_wrap;
  logic [NREQ-1:0]  rr_exp [5];

  initial begin
`ifdef SHARED_CNT_SAT_EN
    exp_inc_wrap = 32'hFFFF_FFFF;
    exp_dec_wrap = 32'h0;
`else
    exp_inc_wrap = 32'h0;
    exp_dec_wrap = 32'hFFFF_FFFF;
`endif
    rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
    rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;

    // Reset held with all requests up
    rst = 1'b0; req = 4'b1111; op = '0; ld_val = '0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_gnt", 64'(gnt), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
    end
    rst = 1'b1;
    tick();
    chk("first_gnt", 64'(gnt), 64'b0001);
    chk("first_count", 64'(count), 64'd1);
    chk("first_busy", 64'(busy), 64'd1);
    release_req();

    // Single INC from 5 on requester 2 (pointer is 1 here)
    do_cmd(1, LD, 32'd5);
    chk("ld5_gnt", 64'(gnt), 64'b0010);
    chk("ld5_count", 64'(count), 64'd5);
    release_req();
    do_cmd(2, INC, 32'd0);
    chk("inc_gnt", 64'(gnt), 64'b0100);
    chk("inc_id", 64'(gnt_id), 64'd2);
    chk("inc_count", 64'(count), 64'd6);
    chk("inc_busy", 64'(busy), 64'd1);
    chk("inc_wrap", 64'(wrap), 64'd0);
    release_req();

    // Contention with pointer at 3: CLEAR (req 3) beats INC (req 0)
    op = {CLR, INC, INC, INC};
    req = 4'b1001;
    tick();
    chk("cont1_gnt", 64'(gnt), 64'b1000);
    chk("cont1_count", 64'(count), 64'd0);
    req = 4'b0001;
    tick();
    chk("cont_ack_gnt", 64'(gnt), 64'd0);
    tick();
    chk("cont2_gnt", 64'(gnt), 64'b0001);
    chk("cont2_count", 64'(count), 64'd1);
    release_req();

    // Round-robin from a fresh reset, all four requesting INC
    rst = 1'b0; tick(); rst = 1'b1;
    op = '0;
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      tick();
      chk("rr_gnt", 64'(gnt), 64'(rr_exp[g]));
      chk("rr_count", 64'(count), 64'(g + 1));
      tick();
      chk("rr_gap", 64'(gnt), 64'd0);
    end
    req = '0;
    tick();
    chk("rr_idle", 64'(gnt), 64'd0);

    // Wrap / saturate at both ends
    do_cmd(1, LD, 32'hFFFF_FFFF);
    chk("ldmax_count", 64'(count), 64'hFFFF_FFFF);
    chk("ldmax_wrap", 64'(wrap), 64'd0);
    release_req();
    do_cmd(0, INC, 32'd0);
    chk("incwrap_count", 64'(count), 64'(exp_inc_wrap));
    chk("incwrap_wrap", 64'(wrap), 64'd1);
    release_req();
    chk("incwrap_clr", 64'(wrap), 64'd0);
    do_cmd(0, CLR, 32'd0);
    chk("clr_count", 64'(count), 64'd0);
    chk("clr_wrap", 64'(wrap), 64'd0);
    release_req();
    do_cmd(0, DEC, 32'd0);
    chk("decwrap_count", 64'(count), 64'(exp_dec_wrap));
    chk("decwrap_wrap", 64'(wrap), 64'd1);
    release_req();

    // Reset in the ACK cycle of a LOAD; pointer must return to 0
    do_cmd(2, LD, 32'h1234);
    chk("ld1234_count", 64'(count), 64'h1234);
    req = '0;
    rst = 1'b0;
    tick();
    chk("midrst_count", 64'(count), 64'd0);
    chk("midrst_gnt", 64'(gnt), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    rst = 1'b1;
    op = '0;
    req = 4'b1010;
    tick();
    chk("midrst_ptr_gnt", 64'(gnt), 64'b0010);
    chk("midrst_ptr_id", 64'(gnt_id), 64'd1);
    chk("midrst_ptr_count", 64'(count), 64'd1);
    release_req();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
